// File: rtl/div_pkg.sv
// Shared types and defaults for the restoring divider.
package div_pkg;

    localparam int WL_DEF = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit, subtract if it fits.
module div_step #(
    parameter int WL = 9
) (
    input  logic [WL-1:0] r,
    input  logic          bit_in,
    input  logic [WL-1:0] divisor,
    output logic [WL-1:0] r_next,
    output logic          q_bit
);

    logic          borrow;
    logic [WL:0]   diff;

    always_comb begin
        {borrow, diff} = {1'b0, r, bit_in} - {2'b00, divisor};
        // r < divisor holds, so a fitting difference never reaches bit WL
        q_bit  = ~(borrow | diff[WL]);
        r_next = q_bit ? diff[WL-1:0] : {r[WL-2:0], bit_in};
    end

endmodule

// File: rtl/div_main.sv
// Sequential restoring divider: 2*WL-bit dividend by WL-bit divisor,
// one quotient bit per cycle, early exit on overflow or divide-by-zero.
module div_main
    import div_pkg::*;
#(
    parameter int WL = WL_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2*WL-1:0] dividend,
    input  logic [WL-1:0]   divisor,
    output logic            busy,
    output logic            done,
    output logic [WL-1:0]   quotient,
    output logic [WL-1:0]   remainder,
    output logic            overflow
);

    localparam int CW = $clog2(WL) + 1;

    state_t        state;
    state_t        state_nx;
    logic [WL-1:0] dvsr;
    logic [WL-1:0] shreg;
    logic [WL-1:0] r;
    logic [CW-1:0] cnt;
    logic [WL-1:0] r_nx;
    logic          q_bit;
    logic          ovf_chk;
    logic          last;
    logic          accept;

    div_step #(.WL(WL)) u_step (
        .r       (r),
        .bit_in  (shreg[WL-1]),
        .divisor (dvsr),
        .r_next  (r_nx),
        .q_bit   (q_bit)
    );

    always_comb begin
        ovf_chk  = (divisor == '0) || (dividend[2*WL-1:WL] >= divisor);
        last     = (cnt == CW'(WL - 1));
        accept   = (state == IDLE) && start;
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = ovf_chk ? DONE : CALC;
            CALC: if (last)  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // shreg feeds dividend bits out the top and collects quotient bits at the bottom
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvsr      <= '0;
            shreg     <= '0;
            r         <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            overflow  <= 1'b0;
        end else if (accept) begin
            dvsr     <= divisor;
            shreg    <= dividend[WL-1:0];
            overflow <= ovf_chk;
            cnt      <= '0;
            if (ovf_chk) begin
                quotient  <= '1;
                remainder <= '0;
                r         <= '0;
            end else begin
                r <= dividend[2*WL-1:WL];
            end
        end else if (state == CALC) begin
            r     <= r_nx;
            shreg <= {shreg[WL-2:0], q_bit};
            cnt   <= cnt + 1'b1;
            if (last) begin
                quotient  <= {shreg[WL-2:0], q_bit};
                remainder <= r_nx;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_div_main.sv
// Scoreboard bench for div_main at WL=9.
module tb_div_main;

    localparam int WL = 9;
    localparam int DW = 2 * WL;

    typedef struct {
        logic [WL-1:0] q;
        logic [WL-1:0] r;
        logic          ov;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [WL-1:0] divisor = '0;
    logic          busy;
    logic          done;
    logic [WL-1:0] quotient;
    logic [WL-1:0] remainder;
    logic          overflow;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_main #(.WL(WL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .overflow  (overflow)
    );

    function automatic exp_t model(input logic [DW-1:0] dd, input logic [WL-1:0] dv);
        exp_t e;
        logic [DW-1:0] qq;
        e.q = '1; e.r = '0; e.ov = 1'b1;
        if (dv != '0) begin
            qq = dd / DW'(dv);
            if (qq < DW'(1 << WL)) begin
                e.q  = qq[WL-1:0];
                e.r  = WL'(dd % DW'(dv));
                e.ov = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic issue(input logic [DW-1:0] dd, input logic [WL-1:0] dv);
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        sb.push_back(model(dd, dv));
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = DW'($urandom);
        divisor  = WL'($urandom);
    endtask

    task automatic wait_done(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, overflow, quotient, remainder} !== '0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b ov=%b q=%0d r=%0d, want all 0",
                     busy, done, overflow, quotient, remainder);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat; bit ok; exp_t e;
        issue(DW'(100), WL'(7));
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy: got %b want 1", busy);
        end
        wait_done(lat, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL basic_timeout: no done within 40 cycles");
        end else begin
            e = sb.pop_front();
            if (quotient !== e.q || remainder !== e.r || overflow !== e.ov
                || quotient !== WL'(14) || remainder !== WL'(2) || lat != 10) begin
                failures++;
                $display("FAIL basic_100_7: q=%0d r=%0d ov=%b lat=%0d want q=14 r=2 ov=0 lat=10",
                         quotient, remainder, overflow, lat);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse: done=%b busy=%b want 0 0", done, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (quotient !== WL'(14) || remainder !== WL'(2) || overflow !== 1'b0) begin
            failures++;
            $display("FAIL result_hold: q=%0d r=%0d ov=%b want 14 2 0",
                     quotient, remainder, overflow);
        end
    endtask

    task automatic test_max();
        int lat; bit ok; exp_t e;
        issue(DW'(261121), WL'(511));
        wait_done(lat, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL max_timeout: no done within 40 cycles");
        end else begin
            e = sb.pop_front();
            if (quotient !== e.q || remainder !== e.r || overflow !== e.ov
                || quotient !== WL'(511) || remainder !== WL'(0)) begin
                failures++;
                $display("FAIL max_511: q=%0d r=%0d ov=%b want q=511 r=0 ov=0",
                         quotient, remainder, overflow);
            end
        end
    endtask

    task automatic test_overflow();
        int lat; bit ok; exp_t e;
        logic [WL-1:0] dvs [2];
        dvs[0] = WL'(3);
        dvs[1] = WL'(0);
        for (int k = 0; k < 2; k++) begin
            issue(DW'(262143), dvs[k]);
            wait_done(lat, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL ovf_timeout: divisor=%0d no done", dvs[k]);
            end else begin
                e = sb.pop_front();
                if (quotient !== e.q || remainder !== e.r || overflow !== e.ov
                    || overflow !== 1'b1 || quotient !== WL'(511) || lat != 1) begin
                    failures++;
                    $display("FAIL ovf_div%0d: q=%0d r=%0d ov=%b lat=%0d want q=511 r=0 ov=1 lat=1",
                             dvs[k], quotient, remainder, overflow, lat);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int ndone; int lat; exp_t e;
        logic [WL-1:0] q0, r0;
        issue(DW'(100), WL'(7));
        repeat (3) @(negedge clk);
        start = 1'b1; dividend = DW'(50); divisor = WL'(5);
        @(negedge clk);
        start = 1'b0;
        ndone = 0; lat = 0; q0 = '0; r0 = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) begin q0 = quotient; r0 = remainder; end
            end
        end
        e = sb.pop_front();
        checks++;
        if (ndone != 1 || q0 !== e.q || r0 !== e.r || busy !== 1'b0) begin
            failures++;
            $display("FAIL start_ignored: dones=%0d q=%0d r=%0d busy=%b want 1 %0d %0d 0",
                     ndone, q0, r0, busy, e.q, e.r);
        end
    endtask

    task automatic test_reset_mid();
        int ndone; int lat; bit ok; exp_t e;
        issue(DW'(100), WL'(7));
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, overflow, quotient, remainder} !== '0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b done=%b ov=%b q=%0d r=%0d want all 0",
                     busy, done, overflow, quotient, remainder);
        end
        sb.delete();
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (done) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            failures++;
            $display("FAIL reset_no_done: dones=%0d want 0", ndone);
        end
        issue(DW'(50), WL'(5));
        wait_done(lat, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL post_reset_timeout: no done");
        end else begin
            e = sb.pop_front();
            if (quotient !== e.q || remainder !== e.r || quotient !== WL'(10)
                || remainder !== WL'(0) || overflow !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_50_5: q=%0d r=%0d ov=%b want 10 0 0",
                         quotient, remainder, overflow);
            end
        end
    endtask

    task automatic test_random();
        int a, b, r, lat; bit ok; exp_t e;
        for (int n = 0; n < 1000; n++) begin
            a = $urandom_range(1, 511);
            b = $urandom_range(1, 511);
            r = $urandom_range(0, b - 1);
            issue(DW'(a * b + r), WL'(b));
            wait_done(lat, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL rand_timeout: a=%0d b=%0d r=%0d", a, b, r);
            end else begin
                e = sb.pop_front();
                if (quotient !== e.q || remainder !== e.r || overflow !== e.ov
                    || quotient !== WL'(a) || remainder !== WL'(r) || lat != 10) begin
                    failures++;
                    $display("FAIL rand_trip: a=%0d b=%0d r=%0d got q=%0d r=%0d ov=%b lat=%0d",
                             a, b, r, quotient, remainder, overflow, lat);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
